i2c_tgt_regs: RTL and testbench
===============================

# i2c_tgt_regs

Synthesizable I2C target (responder) with a small byte-addressed register file, the far end of the bus driven by the I2C controller under test. It decodes START/STOP, matches a fixed 7-bit address, takes a sub-address pointer, then accepts writes or returns reads with pointer auto-increment. It is instantiated in the bench on the shared SCL/SDA lines for master-mode tests, and is also usable as on-chip register storage.

## Interface
- `SLV_ADDR`, 7'h50: 7-bit target address.
- `DEPTH`, 16: register file bytes, power of 2, 2..256.
- `FILT`, 3: glitch-filter length in clk cycles, ≥1.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `scl_i`  in  1  SCL line level (asynchronous).
- `sda_i`  in  1  SDA line level (asynchronous).
- `sda_oe`  out  1  1 = pull SDA low; 0 = release (open drain).
- `host_we`  in  1  local write strobe.
- `host_addr`  in  $clog2(DEPTH)  local address.
- `host_wdata`  in  8  local write data.
- `host_rdata`  out  8  mem[host_addr], registered.
- `busy`  out  1  high from START to STOP.
- `wr_pulse`  out  1  one-cycle pulse per byte written over I2C.

## Operation
- Reset: `sda_oe`, `busy`, `wr_pulse`, `host_rdata`, pointer and every mem byte = 0; FSM = IDLE. Reset mid-transfer releases SDA immediately (async).
- Front end: 2-FF sync, then a level changes only after FILT consecutive equal samples. Edge events: `scl_rise`, `scl_fall`; START = SDA fall while SCL high; STOP = SDA rise while SCL high.
- FSM states: IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK, WR, WR_ACK, RD, RD_ACK, WAIT.
- START (including repeated START) in any state -> ADDR, bit counter = 0, `busy`=1. STOP in any state -> IDLE, `sda_oe`=0, `busy`=0; partial byte discarded.
- ADDR: shift SDA on `scl_rise`, MSB first, 8 bits. After 8th `scl_fall`: match -> ADDR_ACK with `sda_oe`=1; mismatch -> WAIT (SDA never driven).
- ADDR_ACK released on 9th `scl_fall`. R/W=0 -> SUB. R/W=1 -> RD, load mem[ptr] into shifter and drive MSB.
- SUB: 8 bits -> ptr = byte mod DEPTH; ACK (SUB_ACK) -> WR.
- WR: 8 bits -> mem[ptr] = byte, `wr_pulse`, ptr = (ptr+1) mod DEPTH; ACK (WR_ACK) -> WR.
- RD: `sda_oe` = ~bit, updated after each `scl_fall`; after 8th `scl_fall` release -> RD_ACK; ptr increments at load.
- RD_ACK: sample SDA on `scl_rise`. ACK(0) -> on `scl_fall` load mem[ptr], RD. NACK(1) -> WAIT.
- WAIT: SDA released, ignore bits until START/STOP.
- Pointer wraps DEPTH-1 -> 0 for both reads and writes. Pointer retained across transactions (not reset by START/STOP).
- Simultaneous `host_we` and I2C write to same byte: I2C write wins. Host write to another byte proceeds.
- No clock stretching; general call (0x00) not acknowledged.

## Timing
- Input-to-event latency: 2 + FILT clk cycles; pulses shorter than FILT cycles ignored.
- `sda_oe` changes only in the cycle after a filtered `scl_fall` (or at STOP/reset), never while SCL is filtered high.
- Requires SCL high and low phases ≥ FILT+4 clk cycles, and SDA setup to SCL rise ≥ FILT+2 cycles.
- `host_rdata` valid 1 cycle after `host_addr`; reflects I2C writes the cycle after commit.
- `wr_pulse` asserted the cycle after the 8th `scl_fall` of a data byte.

## Structure
- `i2c_tgt_pkg`: state enum, ACK/NACK constants, bit-count width.
- Sub-module `i2c_tgt_filt`: synchronizer, glitch filter, edge and START/STOP detection; instantiated once, carrying both SCL and SDA.
- Top: FSM, shifter, pointer, mem array.

## Test plan
- Write 0x50/W, ptr 0x03, data 0xA5, 0x5A, STOP -> four ACKs, mem[3]=0xA5, mem[4]=0x5A, two `wr_pulse`.
- Preload mem[15]=0x11 and mem[0]=0x22 via host; write ptr 0x0F, repeated START 0x50/R, master ACK then NACK -> reads 0x11, 0x22 (wrap), SDA released after NACK.
- Address 0x51/W -> NACK (`sda_oe` stays 0 all transfer), no mem change, `busy` drops at STOP.
- STOP after 4 data bits of a write byte -> IDLE, no `wr_pulse`, target byte unchanged.
- `rst_n` low during an ACK slot -> `sda_oe`=0 same cycle; all mem bytes read 0 afterwards.
- SCL glitch of FILT-1 cycles mid-byte -> no extra bit shifted; 0xC3 written intact.

Source files
------------

// File: rtl/i2c_tgt_pkg.sv
// Shared types and constants for the I2C target register block.
//   state_e        : protocol FSM states
//   I2C_ACK/NACK   : SDA level of the acknowledge bit
//   BIT_CNT_W      : width of the per-byte bit counter (counts 0..8)
package i2c_tgt_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_SUB,
    ST_SUB_ACK,
    ST_WR,
    ST_WR_ACK,
    ST_RD,
    ST_RD_ACK,
    ST_WAIT
  } state_e;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  localparam int unsigned            BIT_CNT_W     = 4;
  localparam logic [BIT_CNT_W-1:0]   BITS_PER_BYTE = BIT_CNT_W'(8);

endpackage

// File: rtl/i2c_tgt_filt.sv
// SCL/SDA front end: 2-FF synchronizer, glitch filter and bus event detect.
// Ports:
//   clk, rst_n        : system clock, async active-low reset
//   scl_i, sda_i      : raw (asynchronous) bus levels
//   sda_lvl           : filtered SDA level
//   scl_rise/scl_fall : one-cycle pulses on filtered SCL edges
//   start_det         : SDA fell while SCL high
//   stop_det          : SDA rose while SCL high
module i2c_tgt_filt #(
  parameter int unsigned FILT = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_lvl,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  localparam int unsigned          CNT_W   = (FILT > 1) ? $clog2(FILT) : 1;
  localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(FILT - 1);

  // Index 0 carries SCL, index 1 carries SDA.
  logic [1:0]       meta_q, sync_q, lvl_q, lvl_d;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];
  logic             scl_rise_q, scl_fall_q, start_q, stop_q;
  logic             scl_rise_d, scl_fall_d, start_d, stop_d;

  // A level is accepted after FILT consecutive samples that differ from it.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      lvl_d[i] = lvl_q[i];
      cnt_d[i] = '0;
      if (sync_q[i] != lvl_q[i]) begin
        if (cnt_q[i] == CNT_MAX) lvl_d[i] = sync_q[i];
        else                     cnt_d[i] = CNT_W'(cnt_q[i] + 1'b1);
      end
    end
    scl_rise_d = ~lvl_q[0] &  lvl_d[0];
    scl_fall_d =  lvl_q[0] & ~lvl_d[0];
    // SCL must be high both before and after the SDA transition.
    start_d    =  lvl_q[0] & lvl_d[0] &  lvl_q[1] & ~lvl_d[1];
    stop_d     =  lvl_q[0] & lvl_d[0] & ~lvl_q[1] &  lvl_d[1];
  end

  // Idle bus is high on both lines, so reset to 1 to avoid spurious events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q     <= 2'b11;
      sync_q     <= 2'b11;
      lvl_q      <= 2'b11;
      cnt_q[0]   <= '0;
      cnt_q[1]   <= '0;
      scl_rise_q <= 1'b0;
      scl_fall_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      meta_q     <= {sda_i, scl_i};
      sync_q     <= meta_q;
      lvl_q      <= lvl_d;
      cnt_q[0]   <= cnt_d[0];
      cnt_q[1]   <= cnt_d[1];
      scl_rise_q <= scl_rise_d;
      scl_fall_q <= scl_fall_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
    end
  end

  assign sda_lvl   = lvl_q[1];
  assign scl_rise  = scl_rise_q;
  assign scl_fall  = scl_fall_q;
  assign start_det = start_q;
  assign stop_det  = stop_q;

endmodule

// File: rtl/i2c_tgt_regs.sv
// I2C target with a byte-addressed register file and host-side access port.
// Ports:
//   clk, rst_n          : system clock, async active-low reset
//   scl_i, sda_i        : bus levels (asynchronous)
//   sda_oe              : 1 pulls SDA low, 0 releases it
//   host_we/addr/wdata  : local write port
//   host_rdata          : registered mem[host_addr]
//   busy                : high from START to STOP
//   wr_pulse            : one-cycle pulse per byte written over I2C
module i2c_tgt_regs
  import i2c_tgt_pkg::*;
#(
  parameter logic [6:0]  SLV_ADDR = 7'h50,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned FILT     = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     scl_i,
  input  logic                     sda_i,
  output logic                     sda_oe,
  input  logic                     host_we,
  input  logic [$clog2(DEPTH)-1:0] host_addr,
  input  logic [7:0]               host_wdata,
  output logic [7:0]               host_rdata,
  output logic                     busy,
  output logic                     wr_pulse
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic sda_lvl, scl_rise, scl_fall, start_det, stop_det;

  i2c_tgt_filt #(.FILT(FILT)) u_filt (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .sda_lvl   (sda_lvl),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  state_e               state_q, state_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [7:0]           shift_q, shift_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d, ptr_inc;
  logic                 sda_oe_q, sda_oe_d;
  logic                 busy_q, busy_d;
  logic                 wr_pulse_q, wr_pulse_d;
  logic                 rw_q, rw_d;
  logic                 ack_q, ack_d;
  logic [7:0]           host_rdata_q;
  logic [7:0]           mem_q [DEPTH];
  logic [7:0]           mem_d [DEPTH];
  logic                 i2c_we;
  logic [7:0]           rd_byte;
  logic                 rx_state, rx_full, rx_done;

  assign ptr_inc  = PTR_W'(ptr_q + 1'b1);
  assign rd_byte  = mem_q[ptr_q];
  assign rx_state = (state_q == ST_ADDR) || (state_q == ST_SUB) || (state_q == ST_WR);
  assign rx_full  = (bit_cnt_q == BITS_PER_BYTE);
  assign rx_done  = scl_fall && rx_full;

  // Protocol FSM: bits shift in on SCL rise, all SDA drive changes follow SCL fall.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    wr_pulse_d = 1'b0;
    rw_d       = rw_q;
    ack_d      = ack_q;
    i2c_we     = 1'b0;

    if (stop_det) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      state_d   = ST_ADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b1;
    end else begin
      if (rx_state && scl_rise && !rx_full) begin
        shift_d   = {shift_q[6:0], sda_lvl};
        bit_cnt_d = BIT_CNT_W'(bit_cnt_q + 1'b1);
      end

      case (state_q)
        ST_ADDR: begin
          if (rx_done) begin
            bit_cnt_d = '0;
            if (shift_q[7:1] == SLV_ADDR) begin
              state_d  = ST_ADDR_ACK;
              rw_d     = shift_q[0];
              sda_oe_d = 1'b1;
            end else begin
              state_d = ST_WAIT;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            if (rw_q) begin
              state_d  = ST_RD;
              shift_d  = rd_byte;
              sda_oe_d = ~rd_byte[7];
              ptr_d    = ptr_inc;
            end else begin
              state_d = ST_SUB;
            end
          end
        end
        ST_SUB: begin
          if (rx_done) begin
            bit_cnt_d = '0;
            ptr_d     = shift_q[PTR_W-1:0];
            sda_oe_d  = 1'b1;
            state_d   = ST_SUB_ACK;
          end
        end
        ST_SUB_ACK, ST_WR_ACK: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            state_d   = ST_WR;
          end
        end
        ST_WR: begin
          if (rx_done) begin
            bit_cnt_d  = '0;
            i2c_we     = 1'b1;
            wr_pulse_d = 1'b1;
            ptr_d      = ptr_inc;
            sda_oe_d   = 1'b1;
            state_d    = ST_WR_ACK;
          end
        end
        ST_RD: begin
          // Bit 7 is already on the bus at load; each fall presents the next bit.
          if (scl_fall) begin
            if (bit_cnt_q == BIT_CNT_W'(7)) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              state_d   = ST_RD_ACK;
            end else begin
              shift_d   = {shift_q[6:0], 1'b0};
              sda_oe_d  = ~shift_q[6];
              bit_cnt_d = BIT_CNT_W'(bit_cnt_q + 1'b1);
            end
          end
        end
        ST_RD_ACK: begin
          if (scl_rise) ack_d = sda_lvl;
          if (scl_fall) begin
            if (ack_q == I2C_ACK) begin
              state_d   = ST_RD;
              shift_d   = rd_byte;
              sda_oe_d  = ~rd_byte[7];
              ptr_d     = ptr_inc;
              bit_cnt_d = '0;
            end else begin
              state_d = ST_WAIT;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Register file update; the I2C write is applied last so it wins on a collision.
  always_comb begin
    mem_d = mem_q;
    if (host_we) mem_d[host_addr] = host_wdata;
    if (i2c_we)  mem_d[ptr_q]     = shift_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      ptr_q        <= '0;
      sda_oe_q     <= 1'b0;
      busy_q       <= 1'b0;
      wr_pulse_q   <= 1'b0;
      rw_q         <= 1'b0;
      ack_q        <= I2C_NACK;
      host_rdata_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      ptr_q        <= ptr_d;
      sda_oe_q     <= sda_oe_d;
      busy_q       <= busy_d;
      wr_pulse_q   <= wr_pulse_d;
      rw_q         <= rw_d;
      ack_q        <= ack_d;
      host_rdata_q <= mem_q[host_addr];
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign sda_oe     = sda_oe_q;
  assign busy       = busy_q;
  assign wr_pulse   = wr_pulse_q;
  assign host_rdata = host_rdata_q;

endmodule

// File: tb/tb_i2c_tgt_regs.sv
// Bench for i2c_tgt_regs: bit-banged I2C controller on an open-drain SDA line.
module tb_i2c_tgt_regs;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned FILT  = 3;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int          H     = 16;  // SCL half period in clk cycles
  localparam int          Q     = 6;   // SDA change delay after SCL fall

  logic          clk = 1'b0;
  logic          rst_n;
  logic          scl;
  logic          sda_m;
  logic          sda_line;
  logic          sda_oe;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [7:0]    host_wdata;
  logic [7:0]    host_rdata;
  logic          busy;
  logic          wr_pulse;

  int            total = 0;
  int            bad   = 0;
  int            wr_cnt = 0;
  int            oe_cnt = 0;
  logic [7:0]    exp_q [$];

  assign sda_line = sda_m & ~sda_oe;

  i2c_tgt_regs #(.SLV_ADDR(7'h50), .DEPTH(DEPTH), .FILT(FILT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .scl_i      (scl),
    .sda_i      (sda_line),
    .sda_oe     (sda_oe),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata),
    .busy       (busy),
    .wr_pulse   (wr_pulse)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_pulse) wr_cnt++;
    if (sda_oe)   oe_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tick(H);
    scl   = 1'b1; tick(H);
    sda_m = 1'b0; tick(H);
    scl   = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(H);
    scl   = 1'b1; tick(H);
    sda_m = 1'b1; tick(H);
  endtask

  task automatic wbit(input logic b);
    sda_m = b;    tick(H);
    scl   = 1'b1; tick(H);
    scl   = 1'b0; tick(Q);
  endtask

  task automatic rbit(output logic b);
    sda_m = 1'b1; tick(H);
    scl   = 1'b1; tick(H / 2);
    b     = sda_line;
    tick(H / 2);
    scl   = 1'b0; tick(Q);
  endtask

  task automatic wbyte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) wbit(d[i]);
    rbit(ack);
  endtask

  task automatic rbyte(input logic mack, output logic [7:0] d);
    for (int i = 7; i >= 0; i--) rbit(d[i]);
    wbit(mack);
  endtask

  task automatic host_wr(input int a, input logic [7:0] d);
    host_addr  = AW'(a);
    host_wdata = d;
    host_we    = 1'b1;
    tick(1);
    host_we    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; scl = 1'b1; sda_m = 1'b1;
    host_we = 1'b0; host_addr = '0; host_wdata = '0;
    tick(3);
    rst_n = 1'b1;
    tick(3);
    total++; if (sda_oe !== 1'b0)   begin bad++; $display("FAIL reset_sda_oe: got %b want 0", sda_oe); end
    total++; if (busy !== 1'b0)     begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (wr_pulse !== 1'b0) begin bad++; $display("FAIL reset_wr_pulse: got %b want 0", wr_pulse); end
    total++; if (host_rdata !== 8'h00) begin bad++; $display("FAIL reset_rdata: got %h want 00", host_rdata); end
  endtask

  task automatic test_write();
    logic [3:0] acks;
    logic [7:0] e;
    int w0;
    w0 = wr_cnt;
    i2c_start();
    wbyte(8'hA0, acks[3]);
    wbyte(8'h03, acks[2]);
    wbyte(8'hA5, acks[1]); exp_q.push_back(8'hA5);
    wbyte(8'h5A, acks[0]); exp_q.push_back(8'h5A);
    total++; if (acks !== 4'b0000) begin bad++; $display("FAIL write_acks: got %b want 0000", acks); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL write_busy: got %b want 1", busy); end
    i2c_stop(); tick(4);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL write_busy_stop: got %b want 0", busy); end
    total++; if (wr_cnt - w0 != 2) begin bad++; $display("FAIL write_pulses: got %0d want 2", wr_cnt - w0); end
    for (int a = 3; a <= 4; a++) begin
      host_addr = AW'(a); tick(2);
      e = exp_q.pop_front();
      total++; if (host_rdata !== e) begin bad++; $display("FAIL write_mem[%0d]: got %h want %h", a, host_rdata, e); end
    end
  endtask

  task automatic test_read_wrap();
    logic [2:0] acks;
    logic [7:0] d, e;
    host_wr(15, 8'h11); exp_q.push_back(8'h11);
    host_wr(0,  8'h22); exp_q.push_back(8'h22);
    i2c_start();
    wbyte(8'hA0, acks[2]);
    wbyte(8'h0F, acks[1]);
    i2c_start();
    wbyte(8'hA1, acks[0]);
    total++; if (acks !== 3'b000) begin bad++; $display("FAIL read_acks: got %b want 000", acks); end
    rbyte(1'b0, d);
    e = exp_q.pop_front();
    total++; if (d !== e) begin bad++; $display("FAIL read_byte0: got %h want %h", d, e); end
    rbyte(1'b1, d);
    e = exp_q.pop_front();
    total++; if (d !== e) begin bad++; $display("FAIL read_byte1_wrap: got %h want %h", d, e); end
    tick(8);
    total++; if (sda_oe !== 1'b0) begin bad++; $display("FAIL read_release_after_nack: got %b want 0", sda_oe); end
    i2c_stop(); tick(4);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL read_busy_stop: got %b want 0", busy); end
  endtask

  task automatic test_nack_addr();
    logic a0, a1;
    logic [7:0] e;
    int w0, o0;
    w0 = wr_cnt; o0 = oe_cnt;
    exp_q.push_back(8'hA5); exp_q.push_back(8'h5A);
    i2c_start();
    wbyte(8'hA2, a0);
    total++; if (a0 !== 1'b1) begin bad++; $display("FAIL nack_addr_ack: got %b want 1", a0); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL nack_busy: got %b want 1", busy); end
    wbyte(8'h77, a1);
    total++; if (a1 !== 1'b1) begin bad++; $display("FAIL nack_data_ack: got %b want 1", a1); end
    i2c_stop(); tick(4);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL nack_busy_stop: got %b want 0", busy); end
    total++; if (oe_cnt != o0) begin bad++; $display("FAIL nack_sda_driven: got %0d cycles want 0", oe_cnt - o0); end
    total++; if (wr_cnt != w0) begin bad++; $display("FAIL nack_pulses: got %0d want 0", wr_cnt - w0); end
    for (int a = 3; a <= 4; a++) begin
      host_addr = AW'(a); tick(2);
      e = exp_q.pop_front();
      total++; if (host_rdata !== e) begin bad++; $display("FAIL nack_mem[%0d]: got %h want %h", a, host_rdata, e); end
    end
  endtask

  task automatic test_stop_mid_byte();
    logic [1:0] acks;
    logic [7:0] e;
    int w0;
    host_wr(8, 8'h3C); exp_q.push_back(8'h3C);
    w0 = wr_cnt;
    i2c_start();
    wbyte(8'hA0, acks[1]);
    wbyte(8'h08, acks[0]);
    wbit(1'b1); wbit(1'b0); wbit(1'b1); wbit(1'b1);
    i2c_stop(); tick(4);
    total++; if (acks !== 2'b00) begin bad++; $display("FAIL partial_acks: got %b want 00", acks); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL partial_busy: got %b want 0", busy); end
    total++; if (wr_cnt != w0) begin bad++; $display("FAIL partial_pulses: got %0d want 0", wr_cnt - w0); end
    host_addr = AW'(8); tick(2);
    e = exp_q.pop_front();
    total++; if (host_rdata !== e) begin bad++; $display("FAIL partial_mem[8]: got %h want %h", host_rdata, e); end
  endtask

  task automatic test_glitch();
    logic [2:0] acks;
    logic [7:0] d, e;
    int w0;
    d = 8'hC3;
    exp_q.push_back(8'hC3);
    w0 = wr_cnt;
    i2c_start();
    wbyte(8'hA0, acks[2]);
    wbyte(8'h06, acks[1]);
    for (int i = 7; i >= 0; i--) begin
      wbit(d[i]);
      if (i == 4) begin
        // Short SCL high pulse during the low phase.
        scl = 1'b1; tick(FILT - 1);
        scl = 1'b0; tick(Q);
      end
    end
    rbit(acks[0]);
    i2c_stop(); tick(4);
    total++; if (acks !== 3'b000) begin bad++; $display("FAIL glitch_acks: got %b want 000", acks); end
    total++; if (wr_cnt - w0 != 1) begin bad++; $display("FAIL glitch_pulses: got %0d want 1", wr_cnt - w0); end
    host_addr = AW'(6); tick(2);
    e = exp_q.pop_front();
    total++; if (host_rdata !== e) begin bad++; $display("FAIL glitch_mem[6]: got %h want %h", host_rdata, e); end
  endtask

  task automatic test_reset_ack();
    logic [7:0] e;
    logic [7:0] addr_byte;
    addr_byte = 8'hA0;
    i2c_start();
    for (int i = 7; i >= 0; i--) wbit(addr_byte[i]);
    sda_m = 1'b1; tick(H);
    scl   = 1'b1; tick(H / 2);
    total++; if (sda_oe !== 1'b1) begin bad++; $display("FAIL rst_ack_driven: got %b want 1", sda_oe); end
    rst_n = 1'b0;
    #1;
    total++; if (sda_oe !== 1'b0) begin bad++; $display("FAIL rst_async_release: got %b want 0", sda_oe); end
    tick(4);
    rst_n = 1'b1;
    tick(4);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    for (int a = 0; a < DEPTH; a++) exp_q.push_back(8'h00);
    for (int a = 0; a < DEPTH; a++) begin
      host_addr = AW'(a); tick(2);
      e = exp_q.pop_front();
      total++; if (host_rdata !== e) begin bad++; $display("FAIL rst_mem[%0d]: got %h want %h", a, host_rdata, e); end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wrap();
    test_nack_addr();
    test_stop_mid_byte();
    test_glitch();
    test_reset_ack();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
